// File: rtl/stream_select_fifo.sv
// Channel selector feeding a first-word-fall-through FIFO with valid/ready output,
// saturating pass/drop statistics and a sticky overflow flag.
module stream_select_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 3,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LVL_W-1:0]      level,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  overflow,
  input  logic                  clr_stats
);

  logic [SEL_W-1:0] sel_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             flush, pop, req, full, wr, rej;
  logic             ch_valid;
  logic [WIDTH-1:0] ch_data;

  // Out-of-range sel_q matches no channel, so ch_valid stays low.
  always_comb begin
    ch_valid = 1'b0;
    ch_data  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sel_q == SEL_W'(c)) begin
        ch_valid = in_valid[c];
        ch_data  = in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  assign flush     = (sel != sel_q);
  assign out_valid = (level_q != '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign pop       = out_valid && out_ready && !flush;
  assign req       = en && ch_valid && !flush;
  assign wr        = req && (!full || pop);
  assign rej       = req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Clear wins over any same-cycle increment or overflow set.
  always_comb begin
    pass_d = pass_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clr_stats) begin
      pass_d = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (wr && !(&pass_q)) pass_d = pass_q + CNT_W'(1);
      if (rej) begin
        if (!(&drop_q)) drop_d = drop_q + CNT_W'(1);
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pass_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sel_q    <= sel;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pass_q   <= pass_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= ch_data;
  end

  // Gating on occupancy keeps the head at zero after reset without clearing storage.
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign pass_count = pass_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stream_select_fifo.sv
// Directed plus randomized bench for stream_select_fifo against a queue-based model.
module tb_stream_select_fifo;

  localparam int NCH  = 3;
  localparam int DEP  = 16;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        en;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic [3:0]  pass_count;
  logic [3:0]  drop_count;
  logic        overflow;
  logic        clr_stats;

  int vecs = 0;
  int errs = 0;

  byte unsigned m_q[$];
  int           m_sel  = 0;
  int           m_pass = 0;
  int           m_drop = 0;
  int           m_ovf  = 0;

  stream_select_fifo #(
    .WIDTH(8),
    .N_CH (3),
    .DEPTH(16),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .pass_count(pass_count),
    .drop_count(drop_count),
    .overflow  (overflow),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("level", 32'(level), 32'(m_q.size()));
    if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
    chk("pass_count", 32'(pass_count), 32'(m_pass));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then compare.
  task automatic cycle();
    bit flush, popm, reqm, acc;
    byte unsigned d;
    flush = (int'(sel) != m_sel);
    popm  = !flush && (m_q.size() != 0) && out_ready;
    reqm  = !flush && en && (m_sel < NCH) && in_valid[m_sel];
    acc   = reqm && ((m_q.size() < DEP) || popm);
    d     = (m_sel < NCH) ? in_data[m_sel*8 +: 8] : 8'h00;
    if (flush) begin
      m_q.delete();
      m_sel = int'(sel);
    end else begin
      if (popm) void'(m_q.pop_front());
      if (acc) m_q.push_back(d);
    end
    if (clr_stats) begin
      m_pass = 0;
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      if (acc && m_pass < CMAX) m_pass++;
      if (reqm && !acc) begin
        if (m_drop < CMAX) m_drop++;
        m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic strobe(input int ch, input byte unsigned v);
    in_valid = 3'b000;
    in_data  = 24'h0;
    in_valid[ch] = 1'b1;
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic idle_in();
    in_valid = 3'b000;
    in_data  = 24'h0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sel  = 0;
    m_pass = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  initial begin
    int rdy_bias;
    rst = 1'b1; sel = 2'd0; en = 1'b0; in_data = 24'h0; in_valid = 3'b000;
    out_ready = 1'b0; clr_stats = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Three spaced writes on channel 1, then drain back to back
    sel = 2'd1; en = 1'b1; out_ready = 1'b0; idle_in();
    cycle();
    strobe(1, 8'h11); cycle(); idle_in(); cycle();
    strobe(1, 8'h22); cycle(); idle_in(); cycle();
    strobe(1, 8'h33); cycle(); idle_in(); cycle();
    chk("tp1_level", 32'(level), 32'd3);
    chk("tp1_head", 32'(out_data), 32'h11);
    chk("tp1_pass", 32'(pass_count), 32'd3);
    out_ready = 1'b1;
    cycle(); chk("tp1_pop1", 32'(out_data), 32'h22);
    cycle(); chk("tp1_pop2", 32'(out_data), 32'h33);
    cycle(); chk("tp1_empty", 32'(level), 32'd0);

    // Overflow with 20 writes into 16 entries, pass counter saturates
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      strobe(1, 8'(i));
      cycle();
    end
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_drop", 32'(drop_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("sat_pass", 32'(pass_count), 32'd15);
    chk("ovf_head", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    strobe(1, 8'h55);
    cycle();
    chk("fullpop_level", 32'(level), 32'd16);
    chk("fullpop_drop", 32'(drop_count), 32'd4);
    idle_in();
    for (int i = 1; i < 16; i++) begin
      chk("drain_seq", 32'(out_data), 32'(i));
      cycle();
    end
    chk("drain_last", 32'(out_data), 32'h55);
    cycle();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Channel switch with five entries buffered flushes everything
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(1, 8'(8'hA0 + i));
      cycle();
    end
    chk("sw_level5", 32'(level), 32'd5);
    sel = 2'd2;
    in_valid = 3'b110;
    in_data  = {8'hAA, 8'h77, 8'h00};
    cycle();
    chk("sw_valid", 32'(out_valid), 32'd0);
    chk("sw_level", 32'(level), 32'd0);
    chk("sw_pass", 32'(pass_count), 32'd5);
    chk("sw_drop", 32'(drop_count), 32'd0);
    strobe(2, 8'hBB);
    cycle();
    chk("sw_first", 32'(out_data), 32'hBB);

    // Disabled capture and out-of-range channel
    sel = 2'd0; en = 1'b0; idle_in();
    cycle();
    for (int i = 0; i < 10; i++) begin
      strobe(0, 8'(8'h40 + i));
      cycle();
    end
    chk("en0_level", 32'(level), 32'd0);
    chk("en0_pass", 32'(pass_count), 32'd6);
    chk("en0_drop", 32'(drop_count), 32'd0);
    sel = 2'd3; en = 1'b1; idle_in();
    cycle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 3'b111;
      in_data  = 24'(32'h00C0C1C2 + i);
      cycle();
    end
    chk("sel3_level", 32'(level), 32'd0);
    chk("sel3_pass", 32'(pass_count), 32'd6);

    // Clear coinciding with a drop
    sel = 2'd1; idle_in(); cycle();
    for (int i = 0; i < 17; i++) begin
      strobe(1, 8'(8'h60 + i));
      cycle();
    end
    chk("pre_clr_drop", 32'(drop_count), 32'd1);
    strobe(1, 8'hEE);
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_level", 32'(level), 32'd16);

    // Randomized traffic
    rdy_bias = 2;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) rdy_bias = $urandom_range(0, 4);
      if ($urandom_range(0, 31) == 0) sel = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = 3'($urandom);
      in_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 3) < rdy_bias);
      clr_stats = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clr_stats = 1'b0;

    // Reset while draining
    sel = 2'd1; en = 1'b1; out_ready = 1'b0; idle_in();
    cycle();
    for (int i = 0; i < 6; i++) begin
      strobe(1, 8'(8'h30 + i));
      cycle();
    end
    idle_in(); out_ready = 1'b1;
    cycle(); cycle();
    chk("mid_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_pass", 32'(pass_count), 32'd0);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    strobe(1, 8'h9C);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/stream_select_fifo.md
Name: stream_select_fifo

Overview:
Parametrised successor to the fixed three-way filter selector that sits between the filter bank and uart_tx. It selects one of N_CH byte streams (raw RX, MA, FIR, ...) and buffers it in a DEPTH-entry FIFO. It presents a valid/ready handshake to the transmitter, so no sample is lost while tx_ready is low unless the buffer is full. It also keeps pass/drop statistics and a sticky overflow flag for the HEX/LED debug displays.

Parameters:
WIDTH, 8, sample width in bits
N_CH, 3, number of input streams; must be >= 1
DEPTH, 16, FIFO entries; must be a power of two, >= 2
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sel  in  max(1,$clog2(N_CH))  requested channel index
en  in  1  capture enable (TX enable switch)
in_data  in  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
in_valid  in  N_CH  one-cycle strobe per channel
out_data  out  WIDTH  FIFO head; first-word-fall-through
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head this cycle
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
pass_count  out  CNT_W  samples written into the FIFO
drop_count  out  CNT_W  selected-channel samples discarded
overflow  out  1  sticky; set on any full-drop
clr_stats  in  1  synchronous clear of pass_count, drop_count, overflow

Behaviour:
- Reset (asynchronous, immediate): pointers = 0, level = 0, out_valid = 0, out_data = 0, pass_count = 0, drop_count = 0, overflow = 0, sel_q = 0.
- sel_q register holds the active channel. Each cycle, if sel != sel_q:
  - sel_q <= sel.
  - The FIFO is flushed: pointers and level go to 0 at this edge.
  - No write and no pop happen that cycle.
  - A valid sample on the old or new channel that cycle is discarded and not counted.
  - out_valid is 0 in the following cycle.
- If sel_q >= N_CH, the block selects no channel: nothing is written and nothing is counted. The FIFO still drains.
- Pop: pop = out_valid && out_ready. The read pointer advances at that edge.
- Write request: req = en && in_valid[sel_q] && sel_q < N_CH && no flush this cycle.
- When en = 0: input is ignored and not counted as a drop. Draining continues.
- Write accepted when req && (level < DEPTH || pop).
  - Full plus a simultaneous pop is accepted; level stays at DEPTH.
  - The sample goes to the tail, and pass_count is incremented.
- Write rejected when req && level == DEPTH && !pop. drop_count is incremented and overflow <= 1.
- Level: +1 on write only, -1 on pop only, unchanged when both or neither happen.
- Latency: a sample written at edge k is visible on out_data/out_valid in the cycle after edge k, when the FIFO was empty.
- out_data is the memory at the read pointer. It is don't-care when out_valid = 0, except that it is 0 after reset.
- Ordering: strict FIFO order, with no duplication and no reordering.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr_stats: the counters and overflow go to 0 at the edge. clr_stats takes priority over a same-cycle increment or set. The FIFO is unaffected.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are derived from level.
- Reset mid-transfer: all state clears immediately. out_valid is forced to 0 asynchronously.

Test Plan:
- After reset, sel=1, en=1, strobe ch1 with 0x11, 0x22, 0x33 on non-consecutive cycles, out_ready=0 -> level=3, out_data=0x11, pass_count=3. Then out_ready=1 -> 0x11, 0x22, 0x33 pop on consecutive cycles and level returns to 0.
- DEPTH=16, out_ready=0, write 20 samples 0x00..0x13 -> level=16, drop_count=4, overflow=1. Drain -> out_data sequence is 0x00..0x0F.
- Full FIFO, out_ready=1 and a write in the same cycle -> write accepted, level stays 16, drop_count unchanged.
- With level=5, change sel 1->2 while ch2 strobes 0xAA that cycle -> next cycle out_valid=0, level=0, counts unchanged. A subsequent ch2 0xBB is output first.
- en=0 while strobing ch0 ten times -> level, pass_count and drop_count unchanged. sel=3 with N_CH=3 -> nothing written.
- CNT_W=4: 20 accepted writes -> pass_count=15 (saturated). clr_stats asserted in the same cycle as a drop -> drop_count=0, overflow=0. Assert rst mid-drain -> all outputs 0 immediately.
